mem_ctrl: RTL
=============

# mem_ctrl

Byte-serial memory controller between the 8-bit RAM/IO bus and the two memory clients, the instruction cache (miss refills) and the load/store buffer. It arbitrates requests, splits each 1/2/4-byte access into sequential byte cycles, and assembles or scatters little-endian data. It returns one-cycle completion pulses to each client.

## Interface
- No parameters.
- `clk` in 1: clock.
- `rst` in 1: **asynchronous, active-low** reset.
- `rdy` in 1: global run enable.
  - Low: FSM, counters and issue are frozen; `mem_wr` forced 0.
- `flush` in 1: mispredict squash.
- `ic_enable` in 1: ICache requests a 4-byte fetch.
- `ic_addr` in 32: fetch address.
- `ic_data` out 32: fetched word.
- `ic_done` out 1: one-cycle pulse; `ic_data` is valid in the same cycle.
- `lsb_enable` in 1: LSB request.
- `lsb_wr` in 1: 1 = store, 0 = load.
- `lsb_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `lsb_addr` in 32: access address.
- `lsb_wdata` in 32: store data; the low N bytes are used.
- `lsb_rdata` out 32: load data, zero-extended to 32 bits.
- `lsb_done` out 1: one-cycle pulse.
- `mem_din` in 8: RAM read byte.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: write strobe.
- `io_buffer_full` in 1: UART TX buffer full.

## Operation
- **States:** IDLE, IFETCH, LOAD, STORE.
- **Reset values:**
  - All outputs are 0.
  - State = IDLE; counters = 0; `pending` = 0.
- **Arbitration in IDLE:**
  - The controller samples requests at the clock edge.
  - `lsb_enable` wins over `ic_enable`.
  - The granted request's address and size are latched; the client must hold its inputs until it sees its done pulse.
  - Requests are ignored in any cycle in which `ic_done` or `lsb_done` is high.
- **Access length:** N = 4 for IFETCH, otherwise N = `lsb_size`+1, with 11 mapping to 4.
- **Byte addressing:** byte i is at latched address + i, in little-endian order.
- **Reads (IFETCH, LOAD):**
  - Issue counter k: each active cycle drives `mem_a` = A+k and increments k, for k < N.
  - `pending` is set for one cycle after each active issue.
  - When `pending` = 1, `mem_din` is captured into byte lane r, then r increments.
  - Capture is not gated by `rdy`.
  - After byte N-1 is captured, the controller pulses done with the assembled data and returns to IDLE.
- **Stores:**
  - Each active cycle drives `mem_a` = A+k, `mem_dout` = byte k, `mem_wr` = 1, and increments k.
  - After byte N-1 is written, the controller pulses `lsb_done` and returns to IDLE.
- **Flush:**
  - In IFETCH or LOAD: abort to IDLE at the edge. No done pulse; `pending` cleared; `mem_wr` stays 0.
  - STORE is never aborted.
  - A flush in IDLE blocks the grant for that cycle.
- **`mem_wr` and `mem_a` outside STORE:**
  - `mem_wr` is 0 outside STORE active cycles.
  - `mem_a` holds its last value when idle.
- **Reset mid-access:** the access is abandoned immediately; no done pulse is produced after release.

## Timing
- The RAM returns the byte for the address presented in cycle c during cycle c+1.
- All read, store and handshake latencies below assume `rdy` = 1 throughout.
- **Read:**
  - Request sampled at the end of cycle 0.
  - `mem_a` = A..A+N-1 in cycles 1..N.
  - Bytes captured at the ends of cycles 2..N+1.
  - Done pulse in cycle N+2: word = 6 cycles, byte = 3 cycles.
- **Store:** writes occur in cycles 1..N; `lsb_done` pulses in cycle N+1.
- **Handshake:**
  - `ic_done` and `lsb_done` are never high together.
  - The earliest next grant is sampled at the end of the cycle after the done pulse.
- **`rdy` low:** issue and the counter freeze; `mem_a` holds; the in-flight byte is still captured; issue resumes at A+k when `rdy` rises.

## Configuration
- **`MEM_CTRL_IO_STALL_EN` defined:**
  - A STORE cycle with `io_buffer_full` = 1 and `mem_a[17:16]` = 2'b11 forces `mem_wr` = 0.
  - k does not advance; the byte is retried the next cycle.
- **Undefined:** `io_buffer_full` is ignored; IO stores never stall.

## Test plan
- **ICache word read:** RAM[0x100..0x103] = 13,05,10,00; `ic_enable` with `ic_addr` = 0x100.
  - `ic_done` in cycle 6 with `ic_data` = 0x00100513.
  - `mem_a` = 0x100..0x103 in cycles 1..4.
- **Simultaneous requests:** `ic_enable` and an LSB load of byte 0x200 (RAM = 0xAB) in the same cycle.
  - `lsb_done` in cycle 3 with `lsb_rdata` = 0x000000AB.
  - The ICache is then granted; `ic_done` follows 6 cycles after the grant sample.
- **Half store:** `lsb_size` = 01, `lsb_addr` = 0x80, `lsb_wdata` = 0x1234BEEF.
  - Writes EF@0x80 and BE@0x81 in cycles 1–2.
  - `lsb_done` in cycle 3; `mem_wr` = 0 otherwise.
- **Flush mid-fetch:** `flush` in cycle 3 of an IFETCH.
  - No `ic_done` is produced; state returns to IDLE.
  - A new `ic_enable` at 0x104 completes correctly.
- **`rdy` gap:** `rdy` low in cycles 2–4 of a word load at 0x100.
  - `mem_a` holds 0x101 during the gap.
  - `lsb_rdata` = 0x00100513; done arrives 3 cycles late (cycle 9).
- **IO stall (`MEM_CTRL_IO_STALL_EN`):** byte store to 0x30000 with `io_buffer_full` high for cycles 1–2.
  - `mem_wr` = 1 only in cycle 3; `lsb_done` in cycle 4.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM/IO controller arbitrating ICache refills and LSB accesses.
// Optional MEM_CTRL_IO_STALL_EN: hold IO-space store bytes while the UART TX buffer is full.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        ic_enable,
    input  logic [31:0] ic_addr,
    output logic [31:0] ic_data,
    output logic        ic_done,
    input  logic        lsb_enable,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic [31:0] lsb_rdata,
    output logic        lsb_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] ic_data_q, ic_data_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  k_q, k_d;
    logic [2:0]  r_q, r_d;
    logic        pending_q, pending_d;
    logic        ic_done_q, ic_done_d;
    logic        lsb_done_q, lsb_done_d;

    logic        stall;
    logic [2:0]  lsb_n;
    logic [31:0] next_addr;
    logic [31:0] cap_word;

`ifdef MEM_CTRL_IO_STALL_EN
    assign stall = io_buffer_full && (mem_a_q[17:16] == 2'b11);
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign stall          = 1'b0;
`endif

    assign next_addr = addr_q + {29'd0, k_q} + 32'd1;
    assign cap_word  = buf_q | ({24'd0, mem_din} << {r_q[1:0], 3'b000});

    assign ic_data   = ic_data_q;
    assign ic_done   = ic_done_q;
    assign lsb_rdata = lsb_rdata_q;
    assign lsb_done  = lsb_done_q;
    assign mem_a     = mem_a_q;

    always_comb begin
        lsb_n = 3'd4;
        case (lsb_size)
            2'b00:   lsb_n = 3'd1;
            2'b01:   lsb_n = 3'd2;
            default: lsb_n = 3'd4;
        endcase
    end

    always_comb begin
        mem_dout = 8'h00;
        if (state_q == STORE) begin
            case (k_q[1:0])
                2'd0:    mem_dout = wdata_q[7:0];
                2'd1:    mem_dout = wdata_q[15:8];
                2'd2:    mem_dout = wdata_q[23:16];
                default: mem_dout = wdata_q[31:24];
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a_q;
        ic_data_d   = ic_data_q;
        lsb_rdata_d = lsb_rdata_q;
        n_d         = n_q;
        k_d         = k_q;
        r_d         = r_q;
        pending_d   = 1'b0;
        ic_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        mem_wr      = 1'b0;

        case (state_q)
            IDLE: begin
                // A done pulse in flight means the client has not yet dropped its request.
                if (rdy && !flush && !ic_done_q && !lsb_done_q && (lsb_enable || ic_enable)) begin
                    k_d   = 3'd0;
                    r_d   = 3'd0;
                    buf_d = 32'd0;
                    if (lsb_enable) begin
                        state_d = lsb_wr ? STORE : LOAD;
                        addr_d  = lsb_addr;
                        mem_a_d = lsb_addr;
                        wdata_d = lsb_wdata;
                        n_d     = lsb_n;
                    end else begin
                        state_d = IFETCH;
                        addr_d  = ic_addr;
                        mem_a_d = ic_addr;
                        n_d     = 3'd4;
                    end
                end
            end
            IFETCH, LOAD: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (rdy && (k_q < n_q)) begin
                        pending_d = 1'b1;
                        k_d       = k_q + 3'd1;
                        if ((k_q + 3'd1) < n_q) mem_a_d = next_addr;
                    end
                    // The RAM answers one cycle after issue, whether or not rdy is still high.
                    if (pending_q) begin
                        buf_d = cap_word;
                        r_d   = r_q + 3'd1;
                        if (r_q == (n_q - 3'd1)) begin
                            state_d = IDLE;
                            if (state_q == IFETCH) begin
                                ic_done_d = 1'b1;
                                ic_data_d = cap_word;
                            end else begin
                                lsb_done_d  = 1'b1;
                                lsb_rdata_d = cap_word;
                            end
                        end
                    end
                end
            end
            STORE: begin
                if (rdy && !stall) begin
                    mem_wr = 1'b1;
                    if (k_q == (n_q - 3'd1)) begin
                        state_d    = IDLE;
                        lsb_done_d = 1'b1;
                    end else begin
                        k_d     = k_q + 3'd1;
                        mem_a_d = next_addr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            mem_a_q     <= 32'd0;
            ic_data_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
            n_q         <= 3'd0;
            k_q         <= 3'd0;
            r_q         <= 3'd0;
            pending_q   <= 1'b0;
            ic_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            mem_a_q     <= mem_a_d;
            ic_data_q   <= ic_data_d;
            lsb_rdata_q <= lsb_rdata_d;
            n_q         <= n_d;
            k_q         <= k_d;
            r_q         <= r_d;
            pending_q   <= pending_d;
            ic_done_q   <= ic_done_d;
            lsb_done_q  <= lsb_done_d;
        end
    end

endmodule
